// File: rtl/sorting_result_serializer.sv
// rtl/sorting_result_serializer.sv - ping-pong serializer for sorting-network output vectors
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   x_valid, x, x_label  one-cycle strobe of a complete sorted vector (never stalled)
//   in_ready             at least one bank is empty (status only)
//   m_valid, m_ready     element stream handshake
//   m_data, m_label      current element
//   m_index, m_last      position of the current element, last-element flag
//   overflow             sticky, a vector arrived with no free bank and was dropped

module sorting_result_serializer #(
  parameter int LOG_INPUT_NUM = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int LABEL_WIDTH   = 4
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     x_valid,
  input  logic [DATA_WIDTH*(2**LOG_INPUT_NUM)-1:0]  x,
  input  logic [LABEL_WIDTH*(2**LOG_INPUT_NUM)-1:0] x_label,
  output logic                                     in_ready,
  output logic                                     m_valid,
  input  logic                                     m_ready,
  output logic [DATA_WIDTH-1:0]                    m_data,
  output logic [LABEL_WIDTH-1:0]                   m_label,
  output logic [LOG_INPUT_NUM-1:0]                 m_index,
  output logic                                     m_last,
  output logic                                     overflow
);

  localparam int N = 2 ** LOG_INPUT_NUM;
  localparam logic [LOG_INPUT_NUM-1:0] LAST_IDX = LOG_INPUT_NUM'(N - 1);

  logic [DATA_WIDTH-1:0]    bank_data  [2][N];
  logic [LABEL_WIDTH-1:0]   bank_label [2][N];
  logic [1:0]               full;
  logic                     wr_ptr;
  logic                     rd_ptr;
  logic [LOG_INPUT_NUM-1:0] cnt;
  logic                     overflow_q;

  logic xfer;
  logic last_xfer;
  logic wr_free;

  // Outputs depend only on registered state, so neither x nor m_ready
  // reaches an output combinationally.
  assign m_valid  = full[rd_ptr];
  assign m_data   = bank_data[rd_ptr][cnt];
  assign m_label  = bank_label[rd_ptr][cnt];
  assign m_index  = cnt;
  assign m_last   = m_valid && (cnt == LAST_IDX);
  assign in_ready = ~full[0] | ~full[1];
  assign overflow = overflow_q;

  assign xfer      = m_valid & m_ready;
  assign last_xfer = xfer & (cnt == LAST_IDX);

  // The write bank may also be the bank whose final element leaves this
  // cycle; it is then reusable immediately.
  assign wr_free = ~full[wr_ptr] | ((rd_ptr == wr_ptr) & last_xfer);

  always_ff @(posedge clk) begin
    if (rst) begin
      full       <= 2'b00;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      cnt        <= '0;
      overflow_q <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < N; k++) begin
          bank_data[b][k]  <= '0;
          bank_label[b][k] <= '0;
        end
      end
    end else begin
      if (xfer) begin
        cnt <= cnt + 1'b1;
        if (cnt == LAST_IDX) begin
          full[rd_ptr] <= 1'b0;
          rd_ptr       <= ~rd_ptr;
        end
      end
      // Placed after the drain update so that a capture into the bank being
      // released in the same cycle leaves it marked full.
      if (x_valid) begin
        if (wr_free) begin
          for (int k = 0; k < N; k++) begin
            bank_data[wr_ptr][k]  <= x[DATA_WIDTH*k +: DATA_WIDTH];
            bank_label[wr_ptr][k] <= x_label[LABEL_WIDTH*k +: LABEL_WIDTH];
          end
          full[wr_ptr] <= 1'b1;
          wr_ptr       <= ~wr_ptr;
        end else begin
          overflow_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sorting_result_serializer.sv
// tb/tb_sorting_result_serializer.sv - directed bench for sorting_result_serializer (N=4)

module tb_sorting_result_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        x_valid = 1'b0;
  logic [31:0] x = '0;
  logic [15:0] x_label = '0;
  logic        in_ready;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [7:0]  m_data;
  logic [3:0]  m_label;
  logic [1:0]  m_index;
  logic        m_last;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  sorting_result_serializer #(
    .LOG_INPUT_NUM(2),
    .DATA_WIDTH(8),
    .LABEL_WIDTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .x_valid(x_valid),
    .x(x),
    .x_label(x_label),
    .in_ready(in_ready),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .m_label(m_label),
    .m_index(m_index),
    .m_last(m_last),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] seq_data(input logic [7:0] base);
    return {base + 8'd3, base + 8'd2, base + 8'd1, base};
  endfunction

  function automatic logic [15:0] seq_label(input logic [3:0] base);
    return {base + 4'd3, base + 4'd2, base + 4'd1, base};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    x_valid = 1'b0;
    m_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
    checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_m_data got %h want 00", m_data); end
    checks++; if (m_label !== 4'h0) begin errors++; $display("FAIL reset_m_label got %h want 0", m_label); end
    checks++; if (m_index !== 2'd0) begin errors++; $display("FAIL reset_m_index got %0d want 0", m_index); end
    checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last got %b want 0", m_last); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
  endtask

  task automatic test_basic_drain();
    logic [7:0] ed [4];
    logic [3:0] el [4];
    ed = '{8'h05, 8'h17, 8'h2A, 8'hF0};
    el = '{4'd3, 4'd0, 4'd2, 4'd1};
    do_reset();
    m_ready = 1'b1;
    x = {8'hF0, 8'h2A, 8'h17, 8'h05};
    x_label = {4'd1, 4'd2, 4'd0, 4'd3};
    x_valid = 1'b1;
    tick();
    x_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL basic_valid[%0d] got %b want 1", i, m_valid); end
      checks++; if (m_data !== ed[i]) begin errors++; $display("FAIL basic_data[%0d] got %h want %h", i, m_data, ed[i]); end
      checks++; if (m_label !== el[i]) begin errors++; $display("FAIL basic_label[%0d] got %0d want %0d", i, m_label, el[i]); end
      checks++; if (m_index !== 2'(i)) begin errors++; $display("FAIL basic_index[%0d] got %0d want %0d", i, m_index, i); end
      checks++; if (m_last !== (i == 3)) begin errors++; $display("FAIL basic_last[%0d] got %b want %b", i, m_last, (i == 3)); end
      tick();
    end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL basic_end_valid got %b want 0", m_valid); end
    checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL basic_end_last got %b want 0", m_last); end
  endtask

  task automatic test_backpressure();
    logic [7:0] ed [4];
    logic       pat [7];
    int         idx;
    ed = '{8'h05, 8'h17, 8'h2A, 8'hF0};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    idx = 0;
    do_reset();
    x = {8'hF0, 8'h2A, 8'h17, 8'h05};
    x_label = {4'd1, 4'd2, 4'd0, 4'd3};
    x_valid = 1'b1;
    tick();
    x_valid = 1'b0;
    for (int j = 0; j < 7; j++) begin
      m_ready = pat[j];
      checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %b want 1", j, m_valid); end
      checks++; if (m_data !== ed[idx]) begin errors++; $display("FAIL bp_data[%0d] got %h want %h", j, m_data, ed[idx]); end
      checks++; if (m_index !== 2'(idx)) begin errors++; $display("FAIL bp_index[%0d] got %0d want %0d", j, m_index, idx); end
      tick();
      if (pat[j]) idx++;
    end
    m_ready = 1'b1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL bp_end_valid got %b want 0", m_valid); end
  endtask

  task automatic test_double_buffer();
    do_reset();
    m_ready = 1'b1;
    x = seq_data(8'd1);
    x_label = seq_label(4'd1);
    x_valid = 1'b1;
    tick();
    for (int c = 1; c <= 8; c++) begin
      if (c == 1) begin
        x = seq_data(8'd5);
        x_label = seq_label(4'd5);
        x_valid = 1'b1;
      end else begin
        x_valid = 1'b0;
      end
      checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL db_valid[%0d] got %b want 1", c, m_valid); end
      checks++; if (m_data !== 8'(c)) begin errors++; $display("FAIL db_data[%0d] got %0d want %0d", c, m_data, c); end
      checks++; if (m_label !== 4'(c)) begin errors++; $display("FAIL db_label[%0d] got %0d want %0d", c, m_label, c); end
      checks++; if (m_index !== 2'((c - 1) % 4)) begin errors++; $display("FAIL db_index[%0d] got %0d want %0d", c, m_index, (c - 1) % 4); end
      checks++; if (m_last !== ((c % 4) == 0)) begin errors++; $display("FAIL db_last[%0d] got %b want %b", c, m_last, ((c % 4) == 0)); end
      checks++; if (in_ready !== !(c >= 2 && c <= 4)) begin errors++; $display("FAIL db_in_ready[%0d] got %b want %b", c, in_ready, !(c >= 2 && c <= 4)); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL db_overflow[%0d] got %b want 0", c, overflow); end
      tick();
    end
    x_valid = 1'b0;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL db_end_valid got %b want 0", m_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL db_end_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_overflow();
    logic [7:0] ed [8];
    ed = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h22, 8'h23};
    do_reset();
    m_ready = 1'b0;
    x_valid = 1'b1;
    x = seq_data(8'h10); x_label = seq_label(4'd0);
    tick();
    x = seq_data(8'h20); x_label = seq_label(4'd4);
    tick();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_before got %b want 0", overflow); end
    x = seq_data(8'h30); x_label = seq_label(4'd8);
    tick();
    x_valid = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", overflow); end
    checks++; if (m_data !== 8'h10) begin errors++; $display("FAIL ovf_hold_data got %h want 10", m_data); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ovf_in_ready got %b want 0", in_ready); end
    tick();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid[%0d] got %b want 1", i, m_valid); end
      checks++; if (m_data !== ed[i]) begin errors++; $display("FAIL ovf_data[%0d] got %h want %h", i, m_data, ed[i]); end
      tick();
    end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL ovf_end_valid got %b want 0 (data %h)", m_valid, m_data); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_end_sticky got %b want 1", overflow); end
  endtask

  task automatic test_same_cycle_free();
    do_reset();
    m_ready = 1'b1;
    x = seq_data(8'd1); x_label = seq_label(4'd1);
    x_valid = 1'b1;
    tick();
    for (int c = 1; c <= 12; c++) begin
      if (c == 1) begin
        x = seq_data(8'd5); x_label = seq_label(4'd5); x_valid = 1'b1;
      end else if (c == 4) begin
        x = seq_data(8'd9); x_label = seq_label(4'd9); x_valid = 1'b1;
      end else begin
        x_valid = 1'b0;
      end
      checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL sc_valid[%0d] got %b want 1", c, m_valid); end
      checks++; if (m_data !== 8'(c)) begin errors++; $display("FAIL sc_data[%0d] got %0d want %0d", c, m_data, c); end
      checks++; if (m_index !== 2'((c - 1) % 4)) begin errors++; $display("FAIL sc_index[%0d] got %0d want %0d", c, m_index, (c - 1) % 4); end
      if (c == 5) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL sc_in_ready got %b want 0", in_ready); end
      end
      tick();
    end
    x_valid = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL sc_overflow got %b want 0", overflow); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL sc_end_valid got %b want 0", m_valid); end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    m_ready = 1'b1;
    x = seq_data(8'h40); x_label = seq_label(4'd2);
    x_valid = 1'b1;
    tick();
    x_valid = 1'b0;
    tick();
    tick();
    checks++; if (m_index !== 2'd2) begin errors++; $display("FAIL rm_pre_index got %0d want 2", m_index); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rm_valid got %b want 0", m_valid); end
    checks++; if (m_index !== 2'd0) begin errors++; $display("FAIL rm_index got %0d want 0", m_index); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rm_overflow got %b want 0", overflow); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rm_in_ready got %b want 1", in_ready); end
    x = seq_data(8'h60); x_label = seq_label(4'd7);
    x_valid = 1'b1;
    tick();
    x_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL rm_new_valid[%0d] got %b want 1", i, m_valid); end
      checks++; if (m_data !== 8'(8'h60 + i)) begin errors++; $display("FAIL rm_new_data[%0d] got %h want %h", i, m_data, 8'(8'h60 + i)); end
      checks++; if (m_label !== 4'(7 + i)) begin errors++; $display("FAIL rm_new_label[%0d] got %0d want %0d", i, m_label, 7 + i); end
      checks++; if (m_index !== 2'(i)) begin errors++; $display("FAIL rm_new_index[%0d] got %0d want %0d", i, m_index, i); end
      checks++; if (m_last !== (i == 3)) begin errors++; $display("FAIL rm_new_last[%0d] got %b want %b", i, m_last, (i == 3)); end
      tick();
    end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rm_end_valid got %b want 0", m_valid); end
  endtask

  initial begin
    test_reset();
    test_basic_drain();
    test_backpressure();
    test_double_buffer();
    test_overflow();
    test_same_cycle_free();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
